// File: rtl/sha256_padder.sv
// sha256_padder: SHA-256 message padder turning a byte stream into 512-bit chunks
// Ports: Clk/Reset (async active-low); InData/InValid/InLast/InReady byte input;
// Chunk/ChunkValid/ChunkLast/ChunkReady 512-bit chunk output, byte 0 at Chunk[511:504].
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [7:0]   InData,
    input  logic         InValid,
    input  logic         InLast,
    output logic         InReady,
    output logic [511:0] Chunk,
    output logic         ChunkValid,
    output logic         ChunkLast,
    input  logic         ChunkReady
);
    typedef enum logic [1:0] {ACCUM, PAD, EMIT, LEN} state_e;
    state_e             state_q;
    logic [5:0]         byte_cnt_q;
    logic [LEN_W-1:0]   bit_len_q;
    logic [511:0]       buf_q;
    logic [511:0]       chunk_q;
    logic               chunk_valid_q;
    logic               chunk_last_q;
    logic               last_pending_q;
    logic               len_pending_q;
    logic [8:0]         hi;
    logic [511:0]       buf_ins;
    logic [511:0]       pad_chunk;
    logic [63:0]        len64;
    assign InReady    = (state_q == ACCUM);
    assign Chunk      = chunk_q;
    assign ChunkValid = chunk_valid_q;
    assign ChunkLast  = chunk_last_q;
    assign len64      = 64'(bit_len_q);
    // MSB index of byte n is 511 - 8n, which is the bitwise inverse of 8n in 9 bits
    assign hi         = ~{byte_cnt_q, 3'b000};
    always_comb begin
        buf_ins = buf_q;
        buf_ins[hi -: 8] = InData;
    end
    // Keep bytes below byte_cnt, place 0x80 at byte_cnt, zero above; append the
    // length when it still fits in bytes 56..63
    always_comb begin
        pad_chunk = '0;
        for (int i = 0; i < 64; i++)
            pad_chunk[511-8*i -: 8] = (6'(i) < byte_cnt_q) ? buf_q[511-8*i -: 8] :
                                      (6'(i) == byte_cnt_q) ? 8'h80 : 8'h00;
        if (byte_cnt_q <= 6'd55) pad_chunk[63:0] = len64;
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q        <= ACCUM;
            byte_cnt_q     <= '0;
            bit_len_q      <= '0;
            buf_q          <= '0;
            chunk_q        <= '0;
            chunk_valid_q  <= 1'b0;
            chunk_last_q   <= 1'b0;
            last_pending_q <= 1'b0;
            len_pending_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: if (InValid) begin
                    bit_len_q <= bit_len_q + LEN_W'(8);
                    if (byte_cnt_q == 6'd63) begin
                        chunk_q        <= buf_ins;
                        chunk_last_q   <= 1'b0;
                        chunk_valid_q  <= 1'b1;
                        byte_cnt_q     <= '0;
                        buf_q          <= '0;
                        last_pending_q <= InLast;
                        state_q        <= EMIT;
                    end else begin
                        buf_q      <= buf_ins;
                        byte_cnt_q <= byte_cnt_q + 6'd1;
                        if (InLast) state_q <= PAD;
                    end
                end
                PAD: begin
                    chunk_q        <= pad_chunk;
                    chunk_last_q   <= (byte_cnt_q <= 6'd55);
                    len_pending_q  <= (byte_cnt_q > 6'd55);
                    last_pending_q <= 1'b0;
                    chunk_valid_q  <= 1'b1;
                    state_q        <= EMIT;
                end
                EMIT: if (ChunkReady) begin
                    chunk_valid_q <= 1'b0;
                    if (chunk_last_q) begin
                        state_q    <= ACCUM;
                        bit_len_q  <= '0;
                        byte_cnt_q <= '0;
                        buf_q      <= '0;
                    end else if (last_pending_q) begin
                        state_q    <= PAD;
                        byte_cnt_q <= '0;
                    end else if (len_pending_q) begin
                        state_q <= LEN;
                    end else begin
                        state_q <= ACCUM;
                        buf_q   <= '0;
                    end
                end
                LEN: begin
                    chunk_q       <= {448'b0, len64};
                    chunk_last_q  <= 1'b1;
                    len_pending_q <= 1'b0;
                    chunk_valid_q <= 1'b1;
                    state_q       <= EMIT;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed bench for sha256_padder with hand-computed chunks
module tb_sha256_padder;
    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic [7:0]   InData = 8'h00;
    logic         InValid = 1'b0;
    logic         InLast = 1'b0;
    logic         InReady;
    logic [511:0] Chunk;
    logic         ChunkValid;
    logic         ChunkLast;
    logic         ChunkReady = 1'b1;
    int total = 0;
    int bad = 0;
    localparam logic [511:0] ABC    = {32'h61626380, 416'b0, 64'h18};
    localparam logic [511:0] Z55    = {440'b0, 8'h80, 64'h1B8};
    localparam logic [511:0] A56_1  = {{56{8'h41}}, 8'h80, 56'b0};
    localparam logic [511:0] A56_2  = {448'b0, 64'h1C0};
    localparam logic [511:0] Z64_1  = {64{8'h5A}};
    localparam logic [511:0] Z64_2  = {8'h80, 440'b0, 64'h200};
    sha256_padder dut (
        .Clk(Clk), .Reset(Reset), .InData(InData), .InValid(InValid), .InLast(InLast),
        .InReady(InReady), .Chunk(Chunk), .ChunkValid(ChunkValid), .ChunkLast(ChunkLast),
        .ChunkReady(ChunkReady)
    );
    always #5 Clk = ~Clk;
    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        while (!InReady && n < 50) begin @(negedge Clk); n++; end
        if (!InReady) check("in_ready_timeout", InReady, 1);
        InValid = 1'b1; InData = d; InLast = l;
        @(negedge Clk);
        InValid = 1'b0; InLast = 1'b0;
    endtask
    task automatic send_abc();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
    endtask
    task automatic wait_valid(output int waits);
        waits = 0;
        while (!ChunkValid && waits < 50) begin @(negedge Clk); waits++; end
        if (!ChunkValid) check("chunk_timeout", ChunkValid, 1);
    endtask
    task automatic get_chunk(output logic [511:0] c, output logic l, output int waits);
        wait_valid(waits);
        c = Chunk;
        l = ChunkLast;
        @(negedge Clk);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [511:0] c, snap;
        logic l;
        int w;
        repeat (2) @(negedge Clk);
        check("rst_in_ready", InReady, 1);
        check("rst_valid", ChunkValid, 0);
        check("rst_last", ChunkLast, 0);
        check("rst_chunk", Chunk, 0);
        Reset = 1'b1;
        @(negedge Clk);
        send_abc();
        get_chunk(c, l, w);
        check("abc_chunk", c, ABC);
        check("abc_last", l, 1);
        check("abc_latency", w, 1);
        for (int i = 0; i < 55; i++) send(8'h00, i == 54);
        get_chunk(c, l, w);
        check("z55_chunk", c, Z55);
        check("z55_last", l, 1);
        check("z55_latency", w, 1);
        for (int i = 0; i < 56; i++) send(8'h41, i == 55);
        get_chunk(c, l, w);
        check("a56_c1", c, A56_1);
        check("a56_l1", l, 0);
        get_chunk(c, l, w);
        check("a56_c2", c, A56_2);
        check("a56_l2", l, 1);
        for (int i = 0; i < 64; i++) send(8'h5A, i == 63);
        get_chunk(c, l, w);
        check("z64_c1", c, Z64_1);
        check("z64_l1", l, 0);
        check("z64_latency", w, 0);
        get_chunk(c, l, w);
        check("z64_c2", c, Z64_2);
        check("z64_l2", l, 1);
        ChunkReady = 1'b0;
        send_abc();
        wait_valid(w);
        snap = Chunk;
        check("bp_chunk", snap, ABC);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("bp_stable", Chunk, snap);
            check("bp_valid", ChunkValid, 1);
            check("bp_in_ready", InReady, 0);
        end
        ChunkReady = 1'b1;
        @(negedge Clk);
        check("bp_released", ChunkValid, 0);
        check("bp_in_ready_back", InReady, 1);
        repeat (3) @(negedge Clk);
        check("bp_single_hs", ChunkValid, 0);
        for (int i = 0; i < 10; i++) send(8'h11, 1'b0);
        Reset = 1'b0;
        #1;
        check("rstmsg_in_ready", InReady, 1);
        check("rstmsg_valid", ChunkValid, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        send_abc();
        get_chunk(c, l, w);
        check("rstmsg_chunk", c, ABC);
        check("rstmsg_last", l, 1);
        ChunkReady = 1'b0;
        send_abc();
        wait_valid(w);
        Reset = 1'b0;
        #1;
        check("rstemit_valid", ChunkValid, 0);
        check("rstemit_chunk", Chunk, 0);
        check("rstemit_last", ChunkLast, 0);
        check("rstemit_in_ready", InReady, 1);
        @(negedge Clk);
        Reset = 1'b1;
        ChunkReady = 1'b1;
        @(negedge Clk);
        send_abc();
        get_chunk(c, l, w);
        check("b2b_first", c, ABC);
        send_abc();
        get_chunk(c, l, w);
        check("b2b_second", c, ABC);
        check("b2b_last", l, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
